// File: rtl/apb_reg_slave.sv
// APB slave with four 32-bit registers (index 0 = read-only ID) and a programmable wait count.
// Define APB_REG_SLAVE_PSLVERR_EN to report pslverr_o on misses and ID writes.
module apb_reg_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'hDEAD_CAF0,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h0A9B_0001
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic        pready_o,
    output logic [31:0] prdata_o,
    output logic        pslverr_o
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [2:0]  WAIT_INIT = 3'(WAIT_CYCLES);
    localparam logic [27:0] BASE_TAG  = BASE_ADDR[31:4];

    state_t      state, state_nxt;
    logic [2:0]  wait_cnt;
    logic [29:0] cap_addr;
    logic        cap_write;
    logic [31:0] cap_wdata;
    logic [31:0] reg1, reg2, reg3;

    logic        setup, ready, done, hit, err;
    logic [1:0]  idx;
    logic [31:0] rd_sel;
    logic        unused_addr_lsbs;

    // Byte-lane address bits carry no meaning in a word-wide register window.
    assign unused_addr_lsbs = ^paddr_i[1:0];

    assign setup = psel_i & ~penable_i;
    assign ready = (state == ST_ACCESS) & psel_i & (wait_cnt == 3'd0);
    assign done  = ready & penable_i;
    assign hit   = (cap_addr[29:2] == BASE_TAG);
    assign idx   = cap_addr[1:0];

`ifdef APB_REG_SLAVE_PSLVERR_EN
    assign err = ~hit | (cap_write & (idx == 2'd0));
`else
    assign err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; dropping psel_i in the access phase aborts the transfer
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (setup) state_nxt = ST_ACCESS;
            ST_ACCESS: if (!psel_i || done) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        pready_o  = ready;
        pslverr_o = done & err;
        prdata_o  = 32'h0;
        if (done && !cap_write && hit && !err) prdata_o = rd_sel;
    end

    // Request capture and wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= 3'd0;
            cap_addr  <= 30'h0;
            cap_write <= 1'b0;
            cap_wdata <= 32'h0;
        end else if (state == ST_IDLE && setup) begin
            wait_cnt  <= WAIT_INIT;
            cap_addr  <= paddr_i[31:2];
            cap_write <= pwrite_i;
            cap_wdata <= pwdata_i;
        end else if (state == ST_ACCESS && wait_cnt != 3'd0) begin
            wait_cnt  <= wait_cnt - 3'd1;
        end
    end

    // Register file; index 0 is the constant ID and ignores writes
    always_ff @(posedge clk) begin
        if (reset) begin
            reg1 <= 32'h0;
            reg2 <= 32'h0;
            reg3 <= 32'h0;
        end else if (done && cap_write && hit) begin
            case (idx)
                2'd1:    reg1 <= cap_wdata;
                2'd2:    reg2 <= cap_wdata;
                2'd3:    reg3 <= cap_wdata;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (idx)
            2'd0:    rd_sel = ID_VALUE;
            2'd1:    rd_sel = reg1;
            2'd2:    rd_sel = reg2;
            default: rd_sel = reg3;
        endcase
    end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench: three slaves (WAIT_CYCLES 1, 0, 3) share one APB bus, one selected at a time.
module tb_apb_reg_slave;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = 32'h0, pwdata = 32'h0;
    logic [1:0]  cur = 2'd0;

    logic [2:0]       pready_v, pslverr_v;
    logic [2:0][31:0] prdata_v;

    localparam logic [31:0] ID = 32'h0A9B_0001;
`ifdef APB_REG_SLAVE_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    apb_reg_slave #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .reset(reset), .psel_i(psel && cur == 2'd0), .penable_i(penable && cur == 2'd0),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .pready_o(pready_v[0]), .prdata_o(prdata_v[0]), .pslverr_o(pslverr_v[0]));
    apb_reg_slave #(.WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .reset(reset), .psel_i(psel && cur == 2'd1), .penable_i(penable && cur == 2'd1),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .pready_o(pready_v[1]), .prdata_o(prdata_v[1]), .pslverr_o(pslverr_v[1]));
    apb_reg_slave #(.WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .reset(reset), .psel_i(psel && cur == 2'd2), .penable_i(penable && cur == 2'd2),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .pready_o(pready_v[2]), .prdata_o(prdata_v[2]), .pslverr_o(pslverr_v[2]));

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [7:0]  lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;
    int   cyc = 0;
    int   setup_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    function automatic int wait_of(input logic [1:0] d);
        return (d == 2'd0) ? 1 : (d == 2'd1) ? 0 : 3;
    endfunction

    // Monitor: pops one expectation per completion, otherwise outputs must be quiet
    always @(negedge clk) begin
        exp_t e;
        if (psel && !penable) setup_cyc = cyc;
        if (!reset && psel && penable && pready_v[cur]) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_completion: got pready=1 want no transfer (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                chk("rdata", prdata_v[cur], e.data);
                chk("pslverr", {31'h0, pslverr_v[cur]}, {31'h0, e.err});
                chk("latency", 32'(cyc - setup_cyc), {24'h0, e.lat});
            end
        end else begin
            chk("idle_prdata", prdata_v[cur], 32'h0);
            chk("idle_pslverr", {31'h0, pslverr_v[cur]}, 32'h0);
            if (!(psel && penable)) chk("idle_pready", {31'h0, pready_v[cur]}, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        psel = 1'b0; penable = 1'b0;
        tick();
    endtask

    // One transfer; leaves the bus just past the completion edge so a caller may chain another
    task automatic xfer(input logic [1:0] d, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        exp_t e;
        int   n;
        e.data = exp_rd; e.err = exp_err; e.lat = 8'(1 + wait_of(d));
        q.push_back(e);
        cur = d; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        tick();
        penable = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (pready_v[d]) break;
        end
        if (n == 20) begin
            n_cmp++; n_bad++;
            $display("FAIL pready_timeout: got no pready want pready within 20 cycles (addr %h)", a);
        end
        tick();
    endtask

    initial begin
        repeat (3) tick();
        for (int d = 0; d < 3; d++) begin
            chk("reset_pready", {31'h0, pready_v[d]}, 32'h0);
            chk("reset_prdata", prdata_v[d], 32'h0);
            chk("reset_pslverr", {31'h0, pslverr_v[d]}, 32'h0);
        end
        reset = 1'b0;
        tick();

        // WAIT_CYCLES=1: ID read, write/read back-to-back through byte-offset address
        xfer(0, 0, 32'hDEAD_CAF0, 0, ID, 0);
        idle();
        xfer(0, 1, 32'hDEAD_CAFE, 32'h1234_5678, 0, 0);
        xfer(0, 0, 32'hDEAD_CAFE, 0, 32'h1234_5678, 0);
        idle();
        xfer(0, 1, 32'hDEAD_CAF4, 32'hA5A5_0001, 0, 0);
        xfer(0, 1, 32'hDEAD_CAF8, 32'h0000_BEEF, 0, 0);
        xfer(0, 0, 32'hDEAD_CAF4, 0, 32'hA5A5_0001, 0);
        xfer(0, 0, 32'hDEAD_CAF8, 0, 32'h0000_BEEF, 0);
        idle();

        // Misses and ID writes change nothing
        xfer(0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, ERR_EN);
        idle();
        xfer(0, 0, 32'hDEAD_CAF4, 0, 32'hA5A5_0001, 0);
        xfer(0, 0, 32'hDEAD_CAF8, 0, 32'h0000_BEEF, 0);
        xfer(0, 0, 32'hDEAD_CAFC, 0, 32'h1234_5678, 0);
        xfer(0, 0, 32'h0000_0010, 0, 0, ERR_EN);
        xfer(0, 0, 32'hDEAD_CB00, 0, 0, ERR_EN);
        xfer(0, 1, 32'hDEAD_CAF0, 32'h0000_0001, 0, ERR_EN);
        xfer(0, 0, 32'hDEAD_CAF0, 0, ID, 0);
        idle();

        // WAIT_CYCLES=0: zero-wait read, then write/read chained
        xfer(1, 0, 32'hDEAD_CAF4, 0, 0, 0);
        xfer(1, 1, 32'hDEAD_CAF4, 32'h0000_55AA, 0, 0);
        xfer(1, 0, 32'hDEAD_CAF4, 0, 32'h0000_55AA, 0);
        idle();

        // WAIT_CYCLES=3: latency 4, then an aborted write leaves index 1 alone
        xfer(2, 0, 32'hDEAD_CAF4, 0, 0, 0);
        idle();
        xfer(2, 1, 32'hDEAD_CAF4, 32'h0000_0077, 0, 0);
        idle();
        cur = 2'd2; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'hDEAD_CAF4; pwdata = 32'hCAFE_BABE;
        tick();
        penable = 1'b1;
        tick();
        idle();
        tick();
        xfer(2, 0, 32'hDEAD_CAF4, 0, 32'h0000_0077, 0);
        idle();

        // Reset during the access phase of a write to index 2
        cur = 2'd0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'hDEAD_CAF8; pwdata = 32'hFFFF_FFFF;
        tick();
        penable = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_abort_pready", {31'h0, pready_v[0]}, 32'h0);
        tick();
        idle();
        xfer(0, 0, 32'hDEAD_CAF8, 0, 32'h0, 0);
        xfer(0, 0, 32'hDEAD_CAFC, 0, 32'h0, 0);
        xfer(0, 0, 32'hDEAD_CAF0, 0, ID, 0);
        idle();

        for (int n = 0; n < 10 && q.size() != 0; n++) tick();
        chk("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'hDEAD_CAF0: base of the 16-byte register window.
REQ-002 Parameter WAIT_CYCLES, default 1, range 0..7: number of access-phase cycles with pready_o low before completion.
REQ-003 Parameter ID_VALUE, default 32'h0A9B_0001: constant returned by register 0.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 psel_i  input  1  APB select.
REQ-007 penable_i  input  1  APB enable (access phase).
REQ-008 paddr_i  input  32  APB byte address.
REQ-009 pwrite_i  input  1  1 = write, 0 = read.
REQ-010 pwdata_i  input  32  write data.
REQ-011 pready_o  output  1  transfer completion.
REQ-012 prdata_o  output  32  read data; valid only in a read completion cycle.
REQ-013 pslverr_o  output  1  error response; valid only in a completion cycle.

Function
REQ-014 Register map: paddr_i[31:4] == BASE_ADDR[31:4] is a hit; index = paddr_i[3:2]; paddr_i[1:0] ignored (0xDEAD_CAFE selects index 3).
REQ-015 Index 0 is a read-only ID_VALUE; indices 1..3 are 32-bit read/write registers.
REQ-016 FSM states: ST_IDLE and ST_ACCESS; encoding 1 bit; ST_IDLE after reset.
REQ-017 ST_IDLE: psel_i=1 and penable_i=0 captures paddr_i, pwrite_i and pwdata_i, loads the wait counter with WAIT_CYCLES, and moves to ST_ACCESS; otherwise stays.
REQ-018 ST_ACCESS: pready_o = (wait counter == 0); counter decrements by 1 per cycle while nonzero.
REQ-019 Completion = ST_ACCESS, psel_i=1, penable_i=1, pready_o=1; the next state is ST_IDLE.
REQ-020 Latency: setup cycle T, pready_o high in cycle T+1+WAIT_CYCLES; WAIT_CYCLES=0 gives a zero-wait transfer.
REQ-021 Write completion to a hit index 1..3 updates that register with captured pwdata at the completion edge; the value is readable by the next transfer.
REQ-022 Read completion drives prdata_o = selected register (ID_VALUE for index 0); prdata_o = 0 in all other cycles.
REQ-023 Miss reads return 0; miss writes and writes to index 0 modify nothing.
REQ-024 psel_i deasserted in ST_ACCESS aborts: return to ST_IDLE, no register update, pready_o low.
REQ-025 Back-to-back: a setup cycle immediately after a completion is accepted from ST_IDLE with no idle gap.
REQ-026 pready_o, prdata_o and pslverr_o are 0 in ST_IDLE.

Reset
REQ-027 reset=1 at a rising edge forces ST_IDLE, wait counter 0, registers 1..3 to 32'h0, captured fields to 0, regardless of any in-flight transfer.
REQ-028 Outputs are 0 from the first edge with reset=1 until a new setup cycle after reset is released; an aborted transfer does not modify registers.

Configuration
REQ-029 Macro APB_REG_SLAVE_PSLVERR_EN compiles in error reporting.
REQ-030 With it defined: pslverr_o=1 in the completion cycle of a miss access or a write to index 0; prdata_o=0 then.
REQ-031 Without it: pslverr_o tied to 0; such accesses complete normally per REQ-023.

Verification
REQ-032 Reset, then a read of 0xDEAD_CAF0 -> prdata_o=32'h0A9B_0001 at T+2 (WAIT_CYCLES=1), pslverr_o=0.
REQ-033 Write 32'h1234_5678 to 0xDEAD_CAFE, then read it back-to-back -> pready_o high at T+2 and T+5, read returns 32'h1234_5678.
REQ-034 WAIT_CYCLES=0 and 3: read 0xDEAD_CAF4 -> pready_o rises at T+1 and T+4 respectively, data 0 after reset.
REQ-035 Write to 0x0000_0010 with macro defined -> pslverr_o=1 at completion, registers unchanged; without macro -> pslverr_o=0, registers unchanged.
REQ-036 Assert reset during ST_ACCESS of a write 32'hFFFF_FFFF to index 2 -> pready_o=0 next cycle, subsequent read of index 2 returns 32'h0.
REQ-037 psel_i dropped mid-wait (WAIT_CYCLES=3) of a write to index 1 -> no pready_o, index 1 unchanged.
